wishbone_cfg_master: RTL and testbench
======================================

Name: wishbone_cfg_master

Overview:
- Wishbone initiator that drives the CGRA configuration CSR block from the bus-master side.
- Takes one config command at a time (write or read of a CGRA config address) on a valid/ready interface.
- Expands each command into the required sequence of single Wishbone transfers to the CSR map, then returns a response.
- Used by on-chip bitstream loaders and by test harnesses in place of the management core.

Parameters:
- WISHBONE_BASE_ADDR, 32'h30000000, base of CSR map; offsets are ADDR +0x00, WDATA +0x04, RDATA +0x08, WRITE +0x0C, READ +0x10.
- READ_WAIT, 4, idle cycles between asserting CFG_READ and sampling RDATA (range 0..255).
- TIMEOUT, 16, max cycles stb may stay high without ack (range 1..255, only used with WBM_TIMEOUT_EN).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = config write, 0 = config read
- cmd_addr  in  32  CGRA config address
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  transfer timed out
- wbm_cyc_o, wbm_stb_o  out  1 each  bus request; always equal
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  always 4'b1111 while stb is high, else 0
- wbm_adr_o  out  32  CSR address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data, sampled when ack is high
- wbm_ack_i  in  1  responder ack
- busy  out  1  not in IDLE

Behaviour:
- All outputs are registered. Reset values: every output 0, except cmd_ready, which is 1.
- States: IDLE, W_ADDR, W_DATA, W_PULSE, R_ADDR, R_SET, R_WAIT, R_DATA, R_CLR, RSP.
- Command sequences:
  - Write: W_ADDR (write cmd_addr to +0x00) -> W_DATA (write cmd_wdata to +0x04) -> W_PULSE (write 1 to +0x0C) -> RSP.
  - Read: R_ADDR (+0x00) -> R_SET (write 1 to +0x10) -> R_WAIT (READ_WAIT cycles, bus idle) -> R_DATA (read +0x08, capture wbm_dat_i) -> R_CLR (write 0 to +0x10) -> RSP.
- Command and data latching:
  - Command is accepted on the edge where cmd_valid and cmd_ready are both high.
  - cmd_addr, cmd_wdata and cmd_write are latched on that edge.
  - Later changes on the cmd_* inputs are ignored.
- Bus phase rules:
  - stb rises in the cycle after entering a phase and holds until ack is sampled high.
  - On the ack edge, stb drops. At least one cycle with stb low separates consecutive phases, so the responder never sees back-to-back requests.
  - adr/dat/we are stable for the whole time stb is high.
  - An ack received while stb is low is ignored.
- Latency with a 1-cycle-ack responder (ack registered one edge after the request):
  - Each phase takes 3 cycles.
  - Write: rsp_valid rises 9 cycles after the accept edge.
  - Read: rsp_valid rises 12+READ_WAIT cycles after the accept edge.
- RSP state:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_ready is high.
  - Leaves RSP on the rsp_valid & rsp_ready edge; cmd_ready rises the next cycle.
  - No command is accepted in the same cycle the response is consumed.
- R_WAIT counter:
  - Loaded with READ_WAIT on entry and decremented each cycle.
  - With READ_WAIT = 0, the FSM goes straight to R_DATA after the R_SET gap cycle.
- Reset mid-operation: stb, cyc and rsp_valid drop at the reset edge, and the FSM returns to IDLE. No partial response is produced.

Optional Feature:
- WBM_TIMEOUT_EN defined:
  - A per-phase counter aborts a phase whose stb has been high for TIMEOUT cycles without ack.
  - On abort, stb drops, the remaining phases are skipped, and the FSM goes to RSP with rsp_err = 1 and rsp_rdata = 0.
  - The counter resets at each new phase.
- WBM_TIMEOUT_EN undefined:
  - No counter; each phase waits for ack indefinitely.
  - rsp_err is tied to 0.

Decomposition:
- Shared package holds:
  - CSR offset constants (shared with the responder).
  - FSM state enum.
  - Default READ_WAIT and TIMEOUT.
- One sub-module, wbm_single_xfer: a single-transfer engine.
  - Inputs: start, we, adr, dat.
  - Behaviour: drives cyc/stb/we/sel/adr/dat, returns done, rdata and timeout, and enforces the idle gap after each transfer.
- The top-level FSM sequences phases only.

Test Plan:
- Write, base 32'h30000000, 1-cycle-ack model: cmd addr=32'h00000120, data=32'hDEADBEEF -> bus writes, in order:
  - 32'h00000120 @30000000
  - 32'hDEADBEEF @30000004
  - 1 @3000000C
  - then rsp_valid at cycle 9, rsp_err=0.
- Read with READ_WAIT=4, model returns 32'hCAFE0001 at +0x08 -> writes @30000000 and 1 @30000010, 4 idle cycles, read @30000008, write 0 @30000010; rsp_rdata=32'hCAFE0001 at cycle 16.
- Backpressure: rsp_ready low for 5 cycles -> response stable, cmd_ready stays 0; a second queued cmd is accepted only after the handshake.
- Responder with 3-cycle ack delay and ack pulses while idle -> stb held until ack, one transfer per phase, stray acks ignored.
- WBM_TIMEOUT_EN, TIMEOUT=16, responder never acks -> stb drops after 16 cycles, rsp_err=1, rsp_rdata=0, no further phases issued.
- Reset asserted during R_WAIT -> next cycle stb=0, rsp_valid=0, cmd_ready=1; the next command runs a full sequence.

Source files
------------

// File: rtl/wishbone_cfg_master_pkg.sv
// Shared definitions for the CGRA config Wishbone master: CSR map offsets, FSM state codes
// and default timing parameters.
package wishbone_cfg_master_pkg;

  localparam logic [31:0] CsrAddrOff  = 32'h00;
  localparam logic [31:0] CsrWdataOff = 32'h04;
  localparam logic [31:0] CsrRdataOff = 32'h08;
  localparam logic [31:0] CsrWriteOff = 32'h0C;
  localparam logic [31:0] CsrReadOff  = 32'h10;

  localparam int unsigned DefaultReadWait = 4;
  localparam int unsigned DefaultTimeout  = 16;

  typedef logic [3:0] state_t;

  localparam state_t StIdle   = 4'd0;
  localparam state_t StWAddr  = 4'd1;
  localparam state_t StWData  = 4'd2;
  localparam state_t StWPulse = 4'd3;
  localparam state_t StRAddr  = 4'd4;
  localparam state_t StRSet   = 4'd5;
  localparam state_t StRWait  = 4'd6;
  localparam state_t StRData  = 4'd7;
  localparam state_t StRClr   = 4'd8;
  localparam state_t StRsp    = 4'd9;

  function automatic logic is_bus_phase(input state_t st);
    return (st inside {StWAddr, StWData, StWPulse, StRAddr, StRSet, StRData, StRClr});
  endfunction

endpackage

// File: rtl/wbm_single_xfer.sv
// Single Wishbone transfer engine: registers one request, holds it until ack (or abort when
// WBM_TIMEOUT_EN is defined) and never accepts a new start while stb is still high.
module wbm_single_xfer
  import wishbone_cfg_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  // An ack seen while stb is low is not ours.
  assign done_o  = stb_q & wb_ack_i;
  assign rdata_o = wb_dat_i;

`ifdef WBM_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_o = stb_q & ~wb_ack_i & (tmo_cnt_q == TmoLast);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!stb_q && start_i) begin
      tmo_cnt_d = '0;
    end else if (stb_q) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unsigned UnusedTimeout = TIMEOUT;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (!stb_q) begin
      if (start_i) begin
        stb_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        dat_d = dat_i;
      end
    end else if (wb_ack_i || timeout_o) begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign wb_cyc_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = {4{stb_q}};
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/wishbone_cfg_master.sv
// CGRA config Wishbone master: expands one write/read command into single CSR transfers.
// Optional per-phase abort lives in wbm_single_xfer under WBM_TIMEOUT_EN.
module wishbone_cfg_master
  import wishbone_cfg_master_pkg::*;
#(
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
  parameter int unsigned READ_WAIT          = DefaultReadWait,
  parameter int unsigned TIMEOUT            = DefaultTimeout
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam logic [7:0] WaitInit = 8'(READ_WAIT);

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        xfer_we;
  logic [31:0] xfer_adr;
  logic [31:0] xfer_dat;
  logic        xfer_done;
  logic [31:0] xfer_rdata;
  logic        xfer_tmo;

  // The engine latches these in the first cycle of each phase, while start_q is high.
  always_comb begin
    xfer_we  = 1'b1;
    xfer_adr = WISHBONE_BASE_ADDR;
    xfer_dat = '0;
    case (state_q)
      StWAddr, StRAddr: begin
        xfer_adr = WISHBONE_BASE_ADDR + CsrAddrOff;
        xfer_dat = addr_q;
      end
      StWData: begin
        xfer_adr = WISHBONE_BASE_ADDR + CsrWdataOff;
        xfer_dat = wdata_q;
      end
      StWPulse: begin
        xfer_adr = WISHBONE_BASE_ADDR + CsrWriteOff;
        xfer_dat = 32'd1;
      end
      StRSet: begin
        xfer_adr = WISHBONE_BASE_ADDR + CsrReadOff;
        xfer_dat = 32'd1;
      end
      StRData: begin
        xfer_we  = 1'b0;
        xfer_adr = WISHBONE_BASE_ADDR + CsrRdataOff;
      end
      StRClr: begin
        xfer_adr = WISHBONE_BASE_ADDR + CsrReadOff;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          state_d     = cmd_write ? StWAddr : StRAddr;
          start_d     = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      StWAddr: if (xfer_done) begin
        state_d = StWData;
        start_d = 1'b1;
      end
      StWData: if (xfer_done) begin
        state_d = StWPulse;
        start_d = 1'b1;
      end
      StRAddr: if (xfer_done) begin
        state_d = StRSet;
        start_d = 1'b1;
      end
      StRSet: if (xfer_done) begin
        if (READ_WAIT == 0) begin
          state_d = StRData;
          start_d = 1'b1;
        end else begin
          state_d = StRWait;
          wait_d  = WaitInit;
        end
      end
      StRWait: begin
        if (wait_q <= 8'd1) begin
          state_d = StRData;
          start_d = 1'b1;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      StRData: if (xfer_done) begin
        rsp_rdata_d = xfer_rdata;
        state_d     = StRClr;
        start_d     = 1'b1;
      end
      StWPulse, StRClr: if (xfer_done) begin
        state_d     = StRsp;
        rsp_valid_d = 1'b1;
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Aborted phase: skip everything that is left and report the error.
    if (xfer_tmo && is_bus_phase(state_q)) begin
      state_d     = StRsp;
      start_d     = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  wbm_single_xfer #(
    .TIMEOUT(TIMEOUT)
  ) u_xfer (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .start_i  (start_q),
    .we_i     (xfer_we),
    .adr_i    (xfer_adr),
    .dat_i    (xfer_dat),
    .done_o   (xfer_done),
    .rdata_o  (xfer_rdata),
    .timeout_o(xfer_tmo),
    .wb_cyc_o (wbm_cyc_o),
    .wb_stb_o (wbm_stb_o),
    .wb_we_o  (wbm_we_o),
    .wb_sel_o (wbm_sel_o),
    .wb_adr_o (wbm_adr_o),
    .wb_dat_o (wbm_dat_o),
    .wb_dat_i (wbm_dat_i),
    .wb_ack_i (wbm_ack_i)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wishbone_cfg_master.sv
// Scoreboard bench for wishbone_cfg_master: expected bus transfers and responses are queued
// at command issue and checked by a negedge monitor against a simple CSR responder.
module tb_wishbone_cfg_master;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;

  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} bus_t;
  typedef struct {logic [31:0] rdata; logic err; int lat;} rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int checks = 0, failures = 0, cyc_cnt = 0;
  int ack_delay = 1, dcnt = 0, last_accept = 0, last_hs = -1, rise_lat = -1;
  int run = 0, last_run = 0, stb_rises = 0;
  bit stray_en = 0, no_ack = 0;
  logic [31:0] rd_val = '0;
  logic prev_stb = 0, prev_xfer = 0, prev_rsp_valid = 0;
  logic [64:0] prev_req = '0;

  wishbone_cfg_master #(
    .WISHBONE_BASE_ADDR(Base),
    .READ_WAIT(4),
    .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  // CSR responder: ack after ack_delay cycles of stb; optional stray acks while master idle.
  assign dat_i = (!we && adr == Base + 32'h8) ? rd_val : 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      dcnt <= 0;
    end else if (stb) begin
      if (no_ack || ack) begin
        ack  <= 1'b0;
        dcnt <= 0;
      end else if (dcnt == ack_delay - 1) begin
        ack  <= 1'b1;
        dcnt <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      dcnt <= 0;
      ack  <= stray_en && !ack && !busy && cyc_cnt[0];
    end
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: samples on negedge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 0; prev_xfer = 0; prev_rsp_valid = 0; run = 0;
    end else begin
      check("cyc_eq_stb", cyc, stb);
      check("sel", sel, stb ? 4'hF : 4'h0);
      if (prev_xfer) check("idle_gap", stb, 1'b0);
      if (stb && prev_stb && !prev_xfer) check("req_stable", {we, adr, dat_o}, prev_req);
      if (stb && !prev_stb) stb_rises++;
      if (stb) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (stb && ack) begin
        if (bus_q.size() == 0) check("unexpected_xfer", {we, adr}, 33'h0);
        else begin
          bus_t e;
          e = bus_q.pop_front();
          check("bus_we", we, e.we);
          check("bus_adr", adr, e.adr);
          if (e.we) check("bus_dat", dat_o, e.dat);
        end
      end
      if (cmd_valid && cmd_ready) begin
        last_accept = cyc_cnt + 1;
        if (last_hs >= 0) check("accept_after_rsp", last_accept > last_hs, 1'b1);
      end
      if (rsp_valid && !prev_rsp_valid) rise_lat = cyc_cnt - last_accept;
      if (rsp_valid && rsp_ready) begin
        last_hs = cyc_cnt + 1;
        if (rsp_q.size() == 0) check("unexpected_rsp", rsp_rdata, 32'h0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
          if (r.lat >= 0) check("rsp_latency", rise_lat, r.lat);
        end
      end
      prev_xfer      = stb && ack;
      prev_stb       = stb;
      prev_req       = {we, adr, dat_o};
      prev_rsp_valid = rsp_valid;
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int lat,
                          input bit push_bus);
    int n;
    if (push_bus) begin
      if (w) begin
        bus_q.push_back('{1'b1, Base + 32'h00, a});
        bus_q.push_back('{1'b1, Base + 32'h04, d});
        bus_q.push_back('{1'b1, Base + 32'h0C, 32'd1});
      end else begin
        bus_q.push_back('{1'b1, Base + 32'h00, a});
        bus_q.push_back('{1'b1, Base + 32'h10, 32'd1});
        bus_q.push_back('{1'b0, Base + 32'h08, 32'd0});
        bus_q.push_back('{1'b1, Base + 32'h10, 32'd0});
      end
    end
    rsp_q.push_back('{exp_rd, exp_err, lat});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accepted", n < 300, 1'b1);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the latched command must be used.
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0BAD_0BAD;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || busy || cmd_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < 500, 1'b1);
  endtask

  initial begin
    int n;
    int rises0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_outputs", {busy, rsp_valid, rsp_err, cyc, stb, we, sel}, 10'h0);
    check("rst_data", {rsp_rdata, adr}, 64'h0);
    rst = 1'b0;

    // Basic write and read with a 1-cycle-ack responder.
    send_cmd(1'b1, 32'h0000_0120, 32'hDEAD_BEEF, 32'h0, 1'b0, 9, 1'b1);
    wait_idle();
    rd_val = 32'hCAFE_0001;
    send_cmd(1'b0, 32'h0000_0140, 32'h0, 32'hCAFE_0001, 1'b0, 16, 1'b1);
    wait_idle();

    // Backpressure: response held, second command waits for the handshake.
    rsp_ready = 1'b0;
    rd_val = 32'h1234_5678;
    send_cmd(1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1'b0, 16, 1'b1);
    fork
      send_cmd(1'b1, 32'h0000_0088, 32'h55AA_55AA, 32'h0, 1'b0, 9, 1'b1);
    join_none
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", rsp_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 32'h1234_5678, 1'b0});
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Slow responder with stray acks while idle.
    ack_delay = 3; stray_en = 1'b1;
    n = 0;
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stray_ack_idle", {ack, stb, busy}, 3'b100);
    send_cmd(1'b1, 32'h0000_0200, 32'hA5A5_0001, 32'h0, 1'b0, 15, 1'b1);
    wait_idle();
    repeat (6) @(negedge clk);
    rd_val = 32'h0BEE_F00D;
    send_cmd(1'b0, 32'h0000_0204, 32'h0, 32'h0BEE_F00D, 1'b0, 24, 1'b1);
    wait_idle();
    repeat (6) @(negedge clk);
    ack_delay = 1; stray_en = 1'b0;

`ifdef WBM_TIMEOUT_EN
    // Responder never acks: first phase aborts after 16 stb-high cycles.
    no_ack = 1'b1;
    rises0 = stb_rises;
    send_cmd(1'b1, 32'h0000_0300, 32'h0000_0077, 32'h0, 1'b1, 17, 1'b0);
    wait_idle();
    check("tmo_stb_cycles", last_run, 16);
    check("tmo_one_phase", stb_rises - rises0, 1);
    no_ack = 1'b0;
`endif

    // Reset during R_WAIT aborts the read with no response.
    rd_val = 32'h7777_0000;
    send_cmd(1'b0, 32'h0000_0400, 32'h0, 32'h7777_0000, 1'b0, 16, 1'b1);
    n = 0;
    while (bus_q.size() > 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {stb, cyc, rsp_valid, cmd_ready, busy}, 5'b00010);
    rst = 1'b0;
    bus_q.delete();
    rsp_q.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 1'b0);
    rd_val = 32'h0000_ABCD;
    send_cmd(1'b0, 32'h0000_0408, 32'h0, 32'h0000_ABCD, 1'b0, 16, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
